tow_cyber_key: RTL and testbench

Computer-opponent key emulator for the tug-of-war game. It is the transmitting end of the key-press interface that the player-input conditioner receives. A free-running LFSR is compared against a difficulty setting, and on a hit the block drives an active-low emulated key waveform with a guaranteed hold and release time. Its `key_n` output feeds a second input conditioner exactly as a physical KEY would, which replaces the raw comparator level used for the cyber player today.

---
 rtl/tow_pkg.sv | 6 +
 rtl/tow_lfsr_xnor.sv | 13 +
 rtl/tow_cyber_key.sv | 59 +++++
 tb/tb_tow_cyber_key.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tow_pkg.sv
// tow_pkg: shared state encoding and constants for the cyber key emulator
package tow_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_PRESS, ST_GAP} tow_key_state_t;
  localparam int LFSR_TAP_OFFSET = 3;
  localparam logic KEY_RELEASED = 1'b1;
endpackage

// File: rtl/tow_lfsr_xnor.sv
// tow_lfsr_xnor: free-running XNOR Fibonacci LFSR, all-zero reset state
module tow_lfsr_xnor
  import tow_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk)
    q <= !reset ? '0 : {q[WIDTH-2:0], ~(q[WIDTH-1] ^ q[WIDTH-1-LFSR_TAP_OFFSET])};
endmodule

// File: rtl/tow_cyber_key.sv
// tow_cyber_key: LFSR-triggered emulated key press with guaranteed hold and gap
module tow_cyber_key
  import tow_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int HOLD  = 2,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-2:0] difficulty,
  output logic             key_n,
  output logic             press,
  output logic             busy,
  output logic [WIDTH-1:0] lfsr_q
);
  localparam int CMAX = HOLD > GAP ? HOLD : GAP;
  localparam int CW = $clog2(CMAX + 1);
  tow_key_state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic hit, done;
  tow_lfsr_xnor #(.WIDTH(WIDTH)) u_lfsr (
    .clk  (clk),
    .reset(reset),
    .q    (lfsr_q)
  );
  always_comb begin
    hit = enable && ({1'b0, difficulty} > lfsr_q);
    done = cnt == '0;
    state_d = state;
    cnt_d = done ? cnt : cnt - 1'b1;
    if (state == ST_IDLE && hit) begin
      state_d = ST_PRESS;
      cnt_d = CW'(HOLD - 1);
    end else if (state == ST_PRESS && done) begin
      state_d = ST_GAP;
      cnt_d = CW'(GAP - 1);
    end else if (state == ST_GAP && done) begin
      state_d = ST_IDLE;
    end
  end
  // outputs are registered from the next state so they line up with state
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt <= '0;
      key_n <= KEY_RELEASED;
      press <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      key_n <= state_d == ST_PRESS ? ~KEY_RELEASED : KEY_RELEASED;
      press <= state == ST_IDLE && state_d == ST_PRESS;
      busy <= state_d != ST_IDLE;
    end
  end
endmodule

// File: tb/tb_tow_cyber_key.sv
// tb_tow_cyber_key: scoreboard bench for default and HOLD=3/GAP=1 instances
module tb_tow_cyber_key;
  logic clk = 1'b0, reset = 1'b0, enable = 1'b0;
  logic [8:0] difficulty = '0;
  logic key_a, press_a, busy_a, key_b, press_b, busy_b;
  logic [9:0] lfsr_a, lfsr_b;
  int n_cmp = 0, n_err = 0;
  logic [9:0] m_lfsr = '0;
  int pa = 0, pb = 0;
  typedef struct {logic [2:0] fa; logic [2:0] fb; logic [9:0] l;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  always #5 clk = ~clk;
  tow_cyber_key dut_a (
    .clk(clk), .reset(reset), .enable(enable), .difficulty(difficulty),
    .key_n(key_a), .press(press_a), .busy(busy_a), .lfsr_q(lfsr_a)
  );
  tow_cyber_key #(.WIDTH(10), .HOLD(3), .GAP(1)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .difficulty(difficulty),
    .key_n(key_b), .press(press_b), .busy(busy_b), .lfsr_q(lfsr_b)
  );
  // model phase: 0 idle, 1..h pressed, h+1..h+g gap
  function automatic int next_ph(int ph, bit hit, int h, int g);
    if (ph == 0) return hit ? 1 : 0;
    return ph == h + g ? 0 : ph + 1;
  endfunction
  function automatic logic [2:0] flags(int ph, int h);
    return {!(ph >= 1 && ph <= h), ph == 1, ph != 0};
  endfunction
  task automatic step(input bit r, input bit e, input logic [8:0] d);
    bit hit;
    @(negedge clk);
    reset = r;
    enable = e;
    difficulty = d;
    hit = e && ({1'b0, d} > m_lfsr);
    if (!r) begin
      m_lfsr = '0;
      pa = 0;
      pb = 0;
    end else begin
      pa = next_ph(pa, hit, 2, 2);
      pb = next_ph(pb, hit, 3, 1);
      m_lfsr = {m_lfsr[8:0], ~(m_lfsr[9] ^ m_lfsr[6])};
    end
    sb.push_back('{flags(pa, 2), flags(pb, 3), m_lfsr});
    @(posedge clk);
    #2;
  endtask
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      n_cmp++;
      if ({key_a, press_a, busy_a} !== mon_e.fa) begin
        n_err++;
        $display("FAIL sb_flags_a got key_n/press/busy=%b expected %b at %0t", {key_a, press_a, busy_a}, mon_e.fa, $time);
      end
      n_cmp++;
      if ({key_b, press_b, busy_b} !== mon_e.fb) begin
        n_err++;
        $display("FAIL sb_flags_b got key_n/press/busy=%b expected %b at %0t", {key_b, press_b, busy_b}, mon_e.fb, $time);
      end
      n_cmp++;
      if (lfsr_a !== mon_e.l) begin
        n_err++;
        $display("FAIL sb_lfsr_a got %h expected %h at %0t", lfsr_a, mon_e.l, $time);
      end
      n_cmp++;
      if (lfsr_b !== mon_e.l) begin
        n_err++;
        $display("FAIL sb_lfsr_b got %h expected %h at %0t", lfsr_b, mon_e.l, $time);
      end
    end
  end
  task automatic test_reset();
    logic [9:0] seq [8] = '{10'h001, 10'h003, 10'h007, 10'h00F, 10'h01F, 10'h03F, 10'h07F, 10'h0FE};
    repeat (3) step(0, 1, 9'h1FF);
    n_cmp++;
    if ({key_a, press_a, busy_a, lfsr_a} !== 13'b100_0000000000) begin
      n_err++;
      $display("FAIL reset_values got key_n/press/busy=%b lfsr=%h expected 100 lfsr=000", {key_a, press_a, busy_a}, lfsr_a);
    end
    for (int i = 0; i < 8; i++) begin
      step(1, 0, '0);
      n_cmp++;
      if (lfsr_a !== seq[i]) begin
        n_err++;
        $display("FAIL reset_lfsr_seq[%0d] got %h expected %h", i, lfsr_a, seq[i]);
      end
    end
  endtask
  task automatic test_never_press();
    int presses = 0, lows = 0;
    step(0, 1, '0);
    repeat (2000) begin
      step(1, 1, '0);
      presses += int'(press_a) + int'(press_b);
      lows += int'(!key_a) + int'(!key_b);
    end
    n_cmp++;
    if (presses != 0 || lows != 0) begin
      n_err++;
      $display("FAIL never_press got presses=%0d low_cycles=%0d expected 0/0", presses, lows);
    end
  endtask
  task automatic test_max_difficulty();
    logic kv [41];
    logic pv [41];
    int last = -100, close = 0;
    step(0, 1, 9'h1FF);
    for (int i = 1; i <= 40; i++) begin
      step(1, 1, 9'h1FF);
      kv[i] = key_a;
      pv[i] = press_a;
    end
    n_cmp++;
    if ({kv[1], kv[2], kv[3], kv[4]} !== 4'b0011) begin
      n_err++;
      $display("FAIL max_key_shape got key_n[1..4]=%b expected 0011", {kv[1], kv[2], kv[3], kv[4]});
    end
    n_cmp++;
    if ({pv[1], pv[2], pv[3], pv[4], pv[5], pv[6]} !== 6'b100001) begin
      n_err++;
      $display("FAIL max_press_cycles got press[1..6]=%b expected 100001", {pv[1], pv[2], pv[3], pv[4], pv[5], pv[6]});
    end
    for (int i = 1; i <= 40; i++)
      if (pv[i]) begin
        if (i - last < 5) close++;
        last = i;
      end
    n_cmp++;
    if (close != 0) begin
      n_err++;
      $display("FAIL max_press_spacing got %0d presses closer than 5 expected 0", close);
    end
  endtask
  task automatic test_enable_drop();
    logic [13:0] kv = '0, bv = '0;
    step(0, 1, 9'h1FF);
    step(1, 1, 9'h1FF);
    n_cmp++;
    if ({press_a, key_a} !== 2'b10) begin
      n_err++;
      $display("FAIL drop_first_press got press/key_n=%b expected 10", {press_a, key_a});
    end
    repeat (14) begin
      step(1, 0, 9'h1FF);
      kv = {kv[12:0], key_a};
      bv = {bv[12:0], busy_a};
    end
    n_cmp++;
    if (kv !== 14'b01111111111111 || bv !== 14'b11100000000000) begin
      n_err++;
      $display("FAIL drop_sequence got key_n=%b busy=%b expected 01111111111111 11100000000000", kv, bv);
    end
  endtask
  task automatic test_reset_mid_press();
    step(0, 1, 9'h1FF);
    step(1, 1, 9'h1FF);
    step(1, 1, 9'h1FF);
    n_cmp++;
    if ({key_a, busy_a} !== 2'b01) begin
      n_err++;
      $display("FAIL midreset_in_press got key_n/busy=%b expected 01", {key_a, busy_a});
    end
    step(0, 1, 9'h1FF);
    n_cmp++;
    if ({key_a, press_a, busy_a, lfsr_a} !== 13'b100_0000000000) begin
      n_err++;
      $display("FAIL midreset_forced got key_n/press/busy=%b lfsr=%h expected 100 lfsr=000", {key_a, press_a, busy_a}, lfsr_a);
    end
  endtask
  task automatic test_params();
    int low = 0, high = 2, pr = 0, runs = 0, total = 0;
    logic prev = 1'b1;
    step(0, 1, 9'h1FF);
    repeat (200) begin
      step(1, 1, 9'h1FF);
      if (!key_b) begin
        if (prev) begin
          n_cmp++;
          if (high < 2) begin
            n_err++;
            $display("FAIL params_gap got high run %0d expected >=2", high);
          end
          low = 0;
          pr = 0;
        end
        low++;
        pr += int'(press_b);
      end else begin
        if (!prev) begin
          runs++;
          n_cmp++;
          if (low != 3 || pr != 1) begin
            n_err++;
            $display("FAIL params_hold got low run %0d presses %0d expected 3/1", low, pr);
          end
          high = 0;
        end
        high++;
      end
      total += int'(press_b);
      prev = key_b;
    end
    n_cmp++;
    if (runs == 0 || (total != runs && total != runs + 1)) begin
      n_err++;
      $display("FAIL params_count got presses %0d completed runs %0d expected one press per run", total, runs);
    end
  endtask
  task automatic test_back_to_back();
    int last = -100, close = 0;
    logic [8:0] d = 9'h100;
    step(0, 1, d);
    for (int i = 0; i < 400; i++) begin
      if (i % 8 == 0) d = 9'($urandom_range(0, 511));
      step($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0, d);
      if (!reset) last = -100;
      else if (press_a) begin
        if (i - last < 5) close++;
        last = i;
      end
    end
    n_cmp++;
    if (close != 0) begin
      n_err++;
      $display("FAIL b2b_spacing got %0d presses closer than 5 expected 0", close);
    end
  endtask
  initial begin
    test_reset();
    test_never_press();
    test_max_difficulty();
    test_enable_drop();
    test_reset_mid_press();
    test_params();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
